i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) engine for a single 7-bit address, the bus-side counterpart to the APB4 I2C controller. It decodes START/STOP/address/data on the open-drain pads, acknowledges matched transfers, and exchanges bytes with local logic through valid/ready handshakes. It stretches SCL when local logic is not ready. A register front end or DMA bridge sits behind it.

## Interface
- SYNC_STAGES, 2: synchronizer depth on scl_i/sda_i; minimum 2.
- clk_i  in  1  system clock; must be ≥ 16× SCL frequency.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  target enable; low releases the bus and forces IDLE.
- addr_i  in  7  own address; sampled when the address byte completes.
- scl_i / sda_i  in  1  pad inputs.
- scl_o / sda_o  out  1  pad output values; constant 0 (open drain).
- scl_dir_o / sda_dir_o  out  1  1 = pad driven low, 0 = released.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  rx_data_o holds an unconsumed byte.
- rx_ready_i  in  1  consumes the byte when high together with rx_valid_o.
- rx_first_o  out  1  rx_data_o is the first byte after the address.
- tx_data_i  in  8  byte to send.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  the engine requests a TX byte; transfer occurs when high together with tx_valid_i.
- busy_o  out  1  addressed (state not IDLE/WAIT).
- stop_o  out  1  one-cycle pulse on STOP ending an addressed transfer.
- nack_o  out  1  one-cycle pulse when the controller NACKs a read byte.

## Operation
- Pads pass through SYNC_STAGES flops. Edges are detected against the previous synced sample.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high.
- Data is sampled on the SCL rising edge. The engine changes its own SDA drive only in the cycle after an SCL falling edge is detected.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
- IDLE: START → ADDR, bit counter = 0.
- ADDR: shift 8 bits MSB first. At the 8th rise, compare [7:1] with addr_i.
  - Match → ADDR_ACK.
  - Mismatch → WAIT (never drives).
- ADDR_ACK: drive SDA low for the 9th bit. At the 9th fall:
  - R/W = 0 → RX.
  - R/W = 1 → TX; assert tx_ready_o.
- RX: shift 8 bits. At the 8th fall:
  - Holding register free: load it, set rx_valid_o, set rx_first_o if this is the first data byte, drive ACK → RX_ACK.
  - Holding register occupied: drive scl_dir_o = 1 (stretch) until it is consumed, then load and ACK.
  - RX_ACK: 9th fall → RX.
- TX: tx_ready_o stays high until tx_valid_i is seen.
  - Without a transfer, SCL is stretched.
  - On transfer: load the shift register, release the stretch, and present the MSB on SDA (drive low iff bit = 0).
  - Each subsequent SCL fall presents the next bit. The 8th fall releases SDA → TX_ACK.
- TX_ACK: sample SDA at the 9th rise.
  - Low (ACK): at the 9th fall, assert tx_ready_o → TX.
  - High (NACK): pulse nack_o → WAIT.
- WAIT: ignore the bus until START (→ ADDR) or STOP (→ IDLE).
- START in any state, including a repeated START: abort the partial byte, release drives → ADDR. The holding register is kept.
- STOP in any state: release drives → IDLE. Pulse stop_o if busy_o was high.
- en_i low: same as STOP, but no stop_o pulse.
- Reset mid-transfer: everything is released. The bus is ignored until the next START. rx_valid_o is cleared and the byte is lost.

## Timing
- Reset values:
  - scl_o, sda_o = 0.
  - scl_dir_o, sda_dir_o, rx_valid_o, rx_first_o, tx_ready_o, busy_o, stop_o, nack_o = 0.
  - rx_data_o = 0.
  - State = IDLE.
- Pad-to-detect latency: SYNC_STAGES + 1 cycles. SDA drive updates one cycle after fall detection.
- rx_valid_o rises the cycle after the 8th-fall detection. It falls the cycle after the rx_valid_o && rx_ready_i handshake.
- A TX handshake on cycle N drives SDA and releases the stretch on cycle N+1.
- A stretch releases one cycle after its condition clears. SCL low time is extended by at least that.
- A STOP and a START detected in the same cycle are impossible (single SDA edge); no priority rule is needed.

## Structure
- i2c_pkg holds:
  - the state enum i2c_tgt_state_e;
  - I2C_ADDR_W = 7 and I2C_BYTE_W = 8;
  - the bit-counter width constant.
- Sub-module i2c_sync_edge (synchronizer plus rise/fall detect), instantiated for SCL and SDA.

## Test plan
- Write to 0x42 with addr_i = 0x42, bytes 0x11, 0x22, rx_ready_i = 1:
  - ACK on all three 9th bits;
  - rx_data_o = 0x11 (rx_first_o = 1), then 0x22 (rx_first_o = 0);
  - stop_o pulses once.
- Address 0x43 with addr_i = 0x42: sda_dir_o stays 0 throughout, busy_o = 0, no rx_valid_o.
- Read from 0x42 with tx 0xA5 then 0x3C, controller ACK then NACK:
  - bus bits observed are 10100101 and 00111100;
  - tx_ready_o is handshaken twice;
  - nack_o pulses once.
- Back-pressure: rx_ready_i = 0 while a second byte arrives. scl_dir_o = 1 until rx_ready_i goes high, then ACK.
- Repeated START (write 0x42 + 0x05, Sr, read 0x42): the engine switches to TX without a stop_o pulse.
- rst_i asserted mid-byte while driving SDA: all dir outputs are 0 next cycle; the following transfer to 0x42 works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target engine.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_CNT_W  = $clog2(I2C_BYTE_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT
  } i2c_tgt_state_e;
endpackage

// File: rtl/i2c_sync_edge.sv
// Pad synchronizer with rise/fall detection against the previous synced sample.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the idle-high bus level so no edge is reported coming out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign q_o    = r_sync[SYNC_STAGES-1];
  assign rise_o = q_o & ~r_prev;
  assign fall_o = ~q_o & r_prev;
endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: decodes the bus, ACKs matched transfers, stretches SCL on back-pressure.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [I2C_ADDR_W-1:0] addr_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  scl_dir_o,
  output logic                  sda_dir_o,
  output logic [I2C_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_first_o,
  input  logic [I2C_BYTE_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  stop_o,
  output logic                  nack_o
);
  localparam logic [I2C_CNT_W-1:0] CNT_LAST = I2C_CNT_W'(I2C_BYTE_W - 1);
  localparam logic [I2C_CNT_W-1:0] CNT_BYTE = I2C_CNT_W'(I2C_BYTE_W);

  logic w_scl_q, w_scl_rise, w_scl_fall;
  logic w_sda_q, w_sda_rise, w_sda_fall;
  logic w_start_det, w_stop_det, w_busy;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (scl_i),
    .q_o (w_scl_q), .rise_o (w_scl_rise), .fall_o (w_scl_fall)
  );
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (sda_i),
    .q_o (w_sda_q), .rise_o (w_sda_rise), .fall_o (w_sda_fall)
  );

  assign w_start_det = w_sda_fall & w_scl_q;
  assign w_stop_det  = w_sda_rise & w_scl_q;

  i2c_tgt_state_e        r_state, w_state_nxt;
  logic [I2C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [I2C_BYTE_W-1:0] r_shift, w_shift_nxt;
  logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
  logic r_rw, w_rw_nxt;
  logic r_sda_drv, w_sda_nxt;
  logic r_scl_drv, w_scl_nxt;
  logic r_rx_valid, w_rx_valid_nxt;
  logic r_rx_first, w_rx_first_nxt;
  logic r_first_pend, w_first_pend_nxt;
  logic r_tx_ready, w_tx_ready_nxt;
  logic r_stop, w_stop_nxt;
  logic r_nack, w_nack_nxt;

  assign w_busy = (r_state != IDLE) && (r_state != WAIT);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shift_nxt      = r_shift;
    w_rx_data_nxt    = r_rx_data;
    w_rw_nxt         = r_rw;
    w_sda_nxt        = r_sda_drv;
    w_scl_nxt        = r_scl_drv;
    w_rx_valid_nxt   = r_rx_valid;
    w_rx_first_nxt   = r_rx_first;
    w_first_pend_nxt = r_first_pend;
    w_tx_ready_nxt   = r_tx_ready;
    w_stop_nxt       = 1'b0;
    w_nack_nxt       = 1'b0;
    if (r_rx_valid && rx_ready_i) w_rx_valid_nxt = 1'b0;

    if (!en_i || w_stop_det) begin
      w_state_nxt    = IDLE;
      w_sda_nxt      = 1'b0;
      w_scl_nxt      = 1'b0;
      w_tx_ready_nxt = 1'b0;
      w_stop_nxt     = en_i && w_busy;
    end else if (w_start_det) begin
      // Any START, repeated or not, abandons the partial byte but keeps the holding register.
      w_state_nxt      = ADDR;
      w_cnt_nxt        = '0;
      w_sda_nxt        = 1'b0;
      w_scl_nxt        = 1'b0;
      w_tx_ready_nxt   = 1'b0;
      w_first_pend_nxt = 1'b1;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], w_sda_q};
            w_cnt_nxt   = r_cnt + I2C_CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              w_rw_nxt    = w_sda_q;
              w_state_nxt = (r_shift[I2C_BYTE_W-2:0] == addr_i) ? ADDR_ACK : WAIT;
            end
          end
        end
        ADDR_ACK: begin
          // First fall (end of bit 8) starts the ACK, second fall (end of bit 9) ends it.
          if (w_scl_fall) begin
            if (!r_sda_drv) begin
              w_sda_nxt = 1'b1;
            end else begin
              w_sda_nxt = 1'b0;
              w_cnt_nxt = '0;
              if (r_rw) begin
                w_state_nxt    = TX;
                w_tx_ready_nxt = 1'b1;
                w_scl_nxt      = 1'b1;
              end else begin
                w_state_nxt = RX;
              end
            end
          end
        end
        RX: begin
          if (!r_scl_drv && w_scl_rise) begin
            w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], w_sda_q};
            w_cnt_nxt   = r_cnt + I2C_CNT_W'(1);
          end else if (r_scl_drv || (w_scl_fall && r_cnt == CNT_BYTE)) begin
            if (r_rx_valid) begin
              w_scl_nxt = 1'b1;
            end else begin
              // SCL stays held here; RX_ACK lets it go once SDA is already low.
              w_rx_data_nxt    = r_shift;
              w_rx_valid_nxt   = 1'b1;
              w_rx_first_nxt   = r_first_pend;
              w_first_pend_nxt = 1'b0;
              w_sda_nxt        = 1'b1;
              w_state_nxt      = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          w_scl_nxt = 1'b0;
          if (w_scl_fall) begin
            w_sda_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = RX;
          end
        end
        TX: begin
          if (r_tx_ready) begin
            if (tx_valid_i) begin
              w_shift_nxt    = tx_data_i;
              w_tx_ready_nxt = 1'b0;
              w_scl_nxt      = 1'b0;
              w_sda_nxt      = ~tx_data_i[I2C_BYTE_W-1];
              w_cnt_nxt      = '0;
            end
          end else if (w_scl_fall) begin
            if (r_cnt == CNT_LAST) begin
              w_sda_nxt   = 1'b0;
              w_state_nxt = TX_ACK;
            end else begin
              w_sda_nxt   = ~r_shift[I2C_BYTE_W-2];
              w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], 1'b0};
              w_cnt_nxt   = r_cnt + I2C_CNT_W'(1);
            end
          end
        end
        TX_ACK: begin
          if (w_scl_rise && w_sda_q) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = WAIT;
          end else if (w_scl_fall) begin
            w_state_nxt    = TX;
            w_tx_ready_nxt = 1'b1;
            w_scl_nxt      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rx_data    <= '0;
      r_rw         <= 1'b0;
      r_sda_drv    <= 1'b0;
      r_scl_drv    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_first_pend <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_stop       <= 1'b0;
      r_nack       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rw         <= w_rw_nxt;
      r_sda_drv    <= w_sda_nxt;
      r_scl_drv    <= w_scl_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_first   <= w_rx_first_nxt;
      r_first_pend <= w_first_pend_nxt;
      r_tx_ready   <= w_tx_ready_nxt;
      r_stop       <= w_stop_nxt;
      r_nack       <= w_nack_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    r_shift <= w_shift_nxt;
  end

  assign scl_o      = 1'b0;
  assign sda_o      = 1'b0;
  assign scl_dir_o  = r_scl_drv;
  assign sda_dir_o  = r_sda_drv;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign rx_first_o = r_rx_first;
  assign tx_ready_o = r_tx_ready;
  assign busy_o     = w_busy;
  assign stop_o     = r_stop;
  assign nack_o     = r_nack;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: behavioural bus controller on wired-AND lines plus an RX scoreboard.
module tb_i2c_target;
  localparam int Q = 10;
  localparam int H = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, en_i, scl_i, sda_i, rx_ready_i, tx_valid_i;
  logic [6:0] addr_i;
  logic [7:0] tx_data_i, rx_data_o;
  logic       scl_o, sda_o, scl_dir_o, sda_dir_o, rx_valid_o, rx_first_o;
  logic       tx_ready_o, busy_o, stop_o, nack_o;

  logic c_scl_low = 1'b0;
  logic c_sda_low = 1'b0;
  assign scl_i = ~(c_scl_low | scl_dir_o);
  assign sda_i = ~(c_sda_low | sda_dir_o);

  logic [7:0] tx_mem [4];
  int tx_idx = 0;
  assign tx_data_i = tx_mem[tx_idx[1:0]];

  i2c_target #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .scl_dir_o(scl_dir_o), .sda_dir_o(sda_dir_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_first_o(rx_first_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .busy_o(busy_o), .stop_o(stop_o), .nack_o(nack_o)
  );

  int total = 0;
  int bad = 0;
  int stop_cnt = 0, nack_cnt = 0, hs_cnt = 0;
  bit sda_seen = 1'b0;
  logic [8:0] exp_rx [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RX handshake pops the next expected {first, data}.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (stop_o) stop_cnt++;
      if (nack_o) nack_cnt++;
      if (tx_ready_o && tx_valid_i) hs_cnt++;
      if (sda_dir_o) sda_seen = 1'b1;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got byte 0x%0h expected none", rx_data_o);
        end else begin
          chk("rx_byte", {23'd0, rx_first_o, rx_data_o}, {23'd0, exp_rx.pop_front()});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_i && tx_ready_o && tx_valid_i) tx_idx <= tx_idx + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_scl();
    int k;
    k = 0;
    c_scl_low = 1'b0;
    while (!scl_i && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!scl_i) begin
      total++;
      bad++;
      $display("FAIL scl_release: SCL low after %0d cycles, expected high", k);
    end
  endtask

  task automatic start_cond();
    cyc(H); c_sda_low = 1'b0;
    cyc(Q); release_scl();
    cyc(Q); c_sda_low = 1'b1;
    cyc(Q); c_scl_low = 1'b1;
  endtask

  task automatic stop_cond();
    cyc(H); c_sda_low = 1'b1;
    cyc(Q); release_scl();
    cyc(Q); c_sda_low = 1'b0;
    cyc(Q);
  endtask

  task automatic write_bit(input logic b);
    cyc(H); c_sda_low = ~b;
    cyc(Q); release_scl();
    cyc(Q); c_scl_low = 1'b1;
  endtask

  task automatic read_bit(output logic b);
    cyc(H); c_sda_low = 1'b0;
    cyc(Q); release_scl();
    cyc(Q / 2); b = sda_i;
    cyc(Q / 2); c_scl_low = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  logic       ack, ack2, bt;
  logic [7:0] rd;
  int s0, n0, h0;

  initial begin
    rst_i = 1'b1; en_i = 1'b1; addr_i = 7'h42; rx_ready_i = 1'b1; tx_valid_i = 1'b1;
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hC3; tx_mem[3] = 8'h00;
    cyc(5);
    chk("rst_scl_o", scl_o, 0);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_scl_dir", scl_dir_o, 0);
    chk("rst_sda_dir", sda_dir_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_first", rx_first_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stop_nack", {stop_o, nack_o}, 0);
    rst_i = 1'b0;
    cyc(5);

    // Plain write of two bytes
    s0 = stop_cnt;
    exp_rx.push_back({1'b1, 8'h11});
    exp_rx.push_back({1'b0, 8'h22});
    start_cond();
    send_byte(8'h84, ack); chk("wr_addr_ack", ack, 0);
    send_byte(8'h11, ack); chk("wr_b0_ack", ack, 0);
    send_byte(8'h22, ack); chk("wr_b1_ack", ack, 0);
    stop_cond(); cyc(10);
    chk("wr_stop_pulses", stop_cnt - s0, 1);

    // Address mismatch
    sda_seen = 1'b0;
    s0 = stop_cnt;
    start_cond();
    send_byte(8'h86, ack); chk("mm_addr_nack", ack, 1);
    cyc(6);
    chk("mm_busy", busy_o, 0);
    stop_cond(); cyc(10);
    chk("mm_sda_never_driven", sda_seen, 0);
    chk("mm_no_stop", stop_cnt - s0, 0);
    chk("mm_rx_valid", rx_valid_o, 0);

    // Read two bytes, ACK then NACK
    h0 = hs_cnt; n0 = nack_cnt;
    start_cond();
    send_byte(8'h85, ack); chk("rd_addr_ack", ack, 0);
    recv_byte(rd, 1'b0); chk("rd_byte0", rd, 8'hA5);
    recv_byte(rd, 1'b1); chk("rd_byte1", rd, 8'h3C);
    stop_cond(); cyc(10);
    chk("rd_tx_handshakes", hs_cnt - h0, 2);
    chk("rd_nack_pulses", nack_cnt - n0, 1);

    // Back-pressure: first byte left unconsumed, second byte must stretch SCL
    rx_ready_i = 1'b0;
    exp_rx.push_back({1'b1, 8'h44});
    exp_rx.push_back({1'b0, 8'h55});
    start_cond();
    send_byte(8'h84, ack); chk("bp_addr_ack", ack, 0);
    send_byte(8'h44, ack); chk("bp_b0_ack", ack, 0);
    fork
      send_byte(8'h55, ack2);
      begin
        int k;
        k = 0;
        while (!scl_dir_o && k < 3000) begin
          cyc(1);
          k++;
        end
        chk("bp_stretch_start", scl_dir_o, 1);
        cyc(40);
        chk("bp_stretch_hold", scl_dir_o, 1);
        chk("bp_no_ack_yet", sda_dir_o, 0);
        rx_ready_i = 1'b1;
      end
    join
    chk("bp_b1_ack", ack2, 0);
    stop_cond(); cyc(10);
    chk("bp_drained", rx_valid_o, 0);

    // Repeated START: write then read without STOP in between
    s0 = stop_cnt; n0 = nack_cnt; h0 = hs_cnt;
    exp_rx.push_back({1'b1, 8'h05});
    start_cond();
    send_byte(8'h84, ack); chk("rs_waddr_ack", ack, 0);
    send_byte(8'h05, ack); chk("rs_b0_ack", ack, 0);
    start_cond();
    chk("rs_no_stop_at_sr", stop_cnt - s0, 0);
    send_byte(8'h85, ack); chk("rs_raddr_ack", ack, 0);
    chk("rs_busy_tx", busy_o, 1);
    recv_byte(rd, 1'b1); chk("rs_rd_byte", rd, 8'hC3);
    stop_cond(); cyc(10);
    chk("rs_handshakes", hs_cnt - h0, 1);
    chk("rs_nack", nack_cnt - n0, 1);

    // Reset while the target is driving SDA mid-byte, then a fresh write
    start_cond();
    send_byte(8'h85, ack); chk("rr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) read_bit(bt);
    cyc(6);
    chk("rr_driving_before_rst", sda_dir_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rr_sda_dir_released", sda_dir_o, 0);
    chk("rr_scl_dir_released", scl_dir_o, 0);
    chk("rr_busy_cleared", busy_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    stop_cond(); cyc(5);
    exp_rx.push_back({1'b1, 8'h77});
    start_cond();
    send_byte(8'h84, ack); chk("rr_wr_addr_ack", ack, 0);
    send_byte(8'h77, ack); chk("rr_wr_b0_ack", ack, 0);
    stop_cond(); cyc(10);

    chk("rx_queue_empty", exp_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
